// File: rtl/load_unit_pkg.sv
// Shared load-type encodings, FSM states and the alignment rule for the data-side load path.
package load_unit_pkg;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Codes 011/110/111 are treated as word loads, so they need word alignment.
    function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] off);
        logic mis;
        case (sel)
            LOAD_LB, LOAD_LBU: mis = 1'b0;
            LOAD_LH, LOAD_LHU: mis = off[0];
            default:           mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_unit_extractor.sv
// Selects the byte/halfword/word lane of a little-endian read word and extends it to 32 bits.
module load_extractor
    import load_unit_pkg::*;
(
    input  logic [2:0]  I_loadsel,
    input  logic [1:0]  I_offset,
    input  logic [31:0] I_data,
    output logic [31:0] O_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = I_data[7:0];
        case (I_offset)
            2'd1:    byte_v = I_data[15:8];
            2'd2:    byte_v = I_data[23:16];
            2'd3:    byte_v = I_data[31:24];
            default: byte_v = I_data[7:0];
        endcase
        half_v = I_offset[1] ? I_data[31:16] : I_data[15:0];

        O_data = I_data;
        case (I_loadsel)
            LOAD_LB:  O_data = {{24{byte_v[7]}}, byte_v};
            LOAD_LBU: O_data = {24'd0, byte_v};
            LOAD_LH:  O_data = {{16{half_v[15]}}, half_v};
            LOAD_LHU: O_data = {16'd0, half_v};
            default:  O_data = I_data;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load path: accepts one load, issues a word-aligned req/ack read, extends the selected lane,
// and reports misalignment or bus timeout with a one-cycle done pulse.
module load_unit
    import load_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        I_clk,
    input  logic        I_rstn,
    input  logic        I_start,
    input  logic [2:0]  I_loadsel,
    input  logic [31:0] I_addr,
    output logic        O_busy,
    output logic        O_done,
    output logic [31:0] O_data,
    output logic        O_misaligned,
    output logic        O_timeout,
    output logic [31:0] O_mem_addr,
    output logic        O_mem_req,
    input  logic        I_mem_ack,
    input  logic [31:0] I_mem_data
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  loadsel_q, loadsel_d;
    logic [1:0]  offset_q, offset_d;
    logic [31:0] data_q, data_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        done_q, done_d;
    logic        mis_q, mis_d;
    logic        to_q, to_d;
    logic [31:0] ext_data;

    load_extractor u_extractor (
        .I_loadsel (loadsel_q),
        .I_offset  (offset_q),
        .I_data    (I_mem_data),
        .O_data    (ext_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        loadsel_d  = loadsel_q;
        offset_d   = offset_q;
        data_d     = data_q;
        mem_addr_d = mem_addr_q;
        done_d     = 1'b0;
        mis_d      = 1'b0;
        to_d       = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (I_start) begin
                    if (is_misaligned(I_loadsel, I_addr[1:0])) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                        data_d  = 32'd0;
                    end else begin
                        loadsel_d  = I_loadsel;
                        offset_d   = I_addr[1:0];
                        mem_addr_d = {I_addr[31:2], 2'b00};
                        cnt_d      = 8'd0;
                        state_d    = ST_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (I_mem_ack) begin
                    data_d  = ext_data;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    data_d  = 32'd0;
                    done_d  = 1'b1;
                    to_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rstn) begin
        if (!I_rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            loadsel_q  <= 3'd0;
            offset_q   <= 2'd0;
            data_q     <= 32'd0;
            mem_addr_q <= 32'd0;
            done_q     <= 1'b0;
            mis_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            loadsel_q  <= loadsel_d;
            offset_q   <= offset_d;
            data_q     <= data_d;
            mem_addr_q <= mem_addr_d;
            done_q     <= done_d;
            mis_q      <= mis_d;
            to_q       <= to_d;
        end
    end

    // Request is decoded from the state flop so an async reset drops it without a clock edge.
    assign O_mem_req    = (state_q == ST_REQ);
    assign O_busy       = (state_q == ST_REQ);
    assign O_done       = done_q;
    assign O_misaligned = mis_q;
    assign O_timeout    = to_q;
    assign O_data       = data_q;
    assign O_mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: expected responses queued at issue, checked by a done monitor.
module tb_load_unit;

    logic        I_clk = 1'b0;
    logic        I_rstn = 1'b0;
    logic        I_start = 1'b0;
    logic [2:0]  I_loadsel = 3'd0;
    logic [31:0] I_addr = 32'd0;
    logic        O_busy, O_done, O_misaligned, O_timeout, O_mem_req;
    logic [31:0] O_data, O_mem_addr;
    logic        I_mem_ack = 1'b0;
    logic [31:0] I_mem_data = 32'd0;

    typedef struct packed {
        logic [31:0] data;
        logic        mis;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    load_unit #(.TIMEOUT(8)) dut (
        .I_clk        (I_clk),
        .I_rstn       (I_rstn),
        .I_start      (I_start),
        .I_loadsel    (I_loadsel),
        .I_addr       (I_addr),
        .O_busy       (O_busy),
        .O_done       (O_done),
        .O_data       (O_data),
        .O_misaligned (O_misaligned),
        .O_timeout    (O_timeout),
        .O_mem_addr   (O_mem_addr),
        .O_mem_req    (O_mem_req),
        .I_mem_ack    (I_mem_ack),
        .I_mem_data   (I_mem_data)
    );

    always #5 I_clk = ~I_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge I_clk) begin
        if (I_rstn && O_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_data", O_data, e.data);
                check("done_misaligned", {31'd0, O_misaligned}, {31'd0, e.mis});
                check("done_timeout", {31'd0, O_timeout}, {31'd0, e.to});
            end
        end
    end

    // Caller must be at a negedge. n_req = REQ cycles, ack in the last one.
    task automatic run_load(input logic [2:0] sel, input logic [31:0] addr,
                            input logic [31:0] mdata, input int n_req,
                            input logic [31:0] exp_data, input bit chain);
        int busy;
        exp_q.push_back('{data: exp_data, mis: 1'b0, to: 1'b0});
        I_start = 1'b1; I_loadsel = sel; I_addr = addr;
        @(negedge I_clk);
        I_start = 1'b0;
        check("req_high", {31'd0, O_mem_req}, 32'd1);
        check("mem_addr", O_mem_addr, {addr[31:2], 2'b00});
        busy = 0;
        for (int i = 0; i < n_req; i++) begin
            if (O_busy) busy++;
            if (i == n_req - 1) begin
                I_mem_ack = 1'b1; I_mem_data = mdata;
            end
            @(negedge I_clk);
        end
        I_mem_ack = 1'b0;
        check("busy_cycles", busy, n_req);
        check("done_high", {31'd0, O_done}, 32'd1);
        check("req_dropped", {31'd0, O_mem_req}, 32'd0);
        if (!chain) begin
            @(negedge I_clk);
            check("done_one_cycle", {31'd0, O_done}, 32'd0);
        end
    endtask

    task automatic run_misaligned(input logic [2:0] sel, input logic [31:0] addr);
        exp_q.push_back('{data: 32'd0, mis: 1'b1, to: 1'b0});
        I_start = 1'b1; I_loadsel = sel; I_addr = addr;
        check("mis_no_req_0", {31'd0, O_mem_req}, 32'd0);
        @(negedge I_clk);
        I_start = 1'b0;
        check("mis_done", {31'd0, O_done}, 32'd1);
        check("mis_no_req_1", {31'd0, O_mem_req}, 32'd0);
        @(negedge I_clk);
        check("mis_done_one_cycle", {31'd0, O_done}, 32'd0);
        check("mis_no_req_2", {31'd0, O_mem_req}, 32'd0);
    endtask

    initial begin
        int req_cnt;
        #12;
        check("rst_busy", {31'd0, O_busy}, 32'd0);
        check("rst_done", {31'd0, O_done}, 32'd0);
        check("rst_req", {31'd0, O_mem_req}, 32'd0);
        check("rst_data", O_data, 32'd0);
        check("rst_mem_addr", O_mem_addr, 32'd0);
        check("rst_flags", {30'd0, O_misaligned, O_timeout}, 32'd0);
        @(negedge I_clk);
        I_rstn = 1'b1;
        @(negedge I_clk);

        run_load(3'b000, 32'h0000_1003, 32'h8012_3456, 3, 32'hFFFF_FF80, 1'b0);
        run_load(3'b100, 32'h0000_1003, 32'h8012_3456, 3, 32'h0000_0080, 1'b0);
        run_load(3'b001, 32'h0000_1002, 32'h8080_1234, 2, 32'hFFFF_8080, 1'b0);
        run_load(3'b101, 32'h0000_1002, 32'h8080_1234, 2, 32'h0000_8080, 1'b0);
        run_load(3'b000, 32'h0000_3002, 32'h007F_0000, 1, 32'h0000_007F, 1'b0);
        run_load(3'b011, 32'h0000_5000, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 1'b0);

        // Word load acked in first REQ cycle, then a start issued during its DONE cycle.
        run_load(3'b010, 32'h0000_2000, 32'h8080_8080, 1, 32'h8080_8080, 1'b1);
        run_load(3'b100, 32'h0000_3001, 32'h1234_A5CD, 2, 32'h0000_00A5, 1'b1);
        run_load(3'b101, 32'h0000_3000, 32'h5555_F00D, 1, 32'h0000_F00D, 1'b0);

        run_misaligned(3'b001, 32'h0000_1001);
        run_misaligned(3'b010, 32'h0000_1002);

        // Timeout: no ack ever.
        exp_q.push_back('{data: 32'd0, mis: 1'b0, to: 1'b1});
        I_start = 1'b1; I_loadsel = 3'b010; I_addr = 32'h0000_4000;
        @(negedge I_clk);
        I_start = 1'b0;
        req_cnt = 0;
        while (O_mem_req === 1'b1 && req_cnt < 50) begin
            req_cnt++;
            @(negedge I_clk);
        end
        check("timeout_req_cycles", req_cnt, 8);
        check("timeout_done", {31'd0, O_done}, 32'd1);
        @(negedge I_clk);
        check("timeout_done_one_cycle", {31'd0, O_done}, 32'd0);

        // Reset while a read is outstanding.
        I_start = 1'b1; I_loadsel = 3'b010; I_addr = 32'h0000_6000;
        @(negedge I_clk);
        I_start = 1'b0;
        check("rst_req_before", {31'd0, O_mem_req}, 32'd1);
        #2 I_rstn = 1'b0;
        #1 check("rst_req_async_drop", {31'd0, O_mem_req}, 32'd0);
        @(negedge I_clk);
        I_rstn = 1'b1;
        I_mem_ack = 1'b1; I_mem_data = 32'h1111_2222;
        @(negedge I_clk);
        I_mem_ack = 1'b0;
        check("rst_ack_no_done", {31'd0, O_done}, 32'd0);
        check("rst_idle_busy", {31'd0, O_busy}, 32'd0);
        repeat (3) @(negedge I_clk);
        check("rst_no_late_done", {31'd0, O_done}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got 1 expected 0");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
Data-side load path of the RISC-V core; the read counterpart of the store path. It accepts one load request from the pipeline and issues a word-aligned read on the data-memory req/ack handshake. It extracts the byte, halfword or word lane from the returned word and sign- or zero-extends it to 32 bits. It stalls the pipeline while the read is outstanding and reports misaligned or timed-out accesses.

Parameters:
TIMEOUT, 255, number of REQ cycles without I_mem_ack before the access is aborted (legal range 1..255)

Ports:
I_clk  in  1  system clock, rising edge
I_rstn  in  1  reset, asynchronous, active-low
I_start  in  1  load request, sampled in IDLE/DONE only
I_loadsel  in  3  load type, RISC-V funct3 encoding
I_addr  in  32  byte address of the load
O_busy  out  1  stall: high while in REQ
O_done  out  1  one-cycle pulse, access finished (good or error)
O_data  out  32  extended load result, held until next accepted start
O_misaligned  out  1  pulse with O_done, alignment fault
O_timeout  out  1  pulse with O_done, bus timeout
O_mem_addr  out  32  {addr[31:2],2'b00}
O_mem_req  out  1  read request, held until ack or timeout
I_mem_ack  in  1  read acknowledge, data valid same cycle
I_mem_data  in  32  read data, little-endian

Behaviour:
- Reset (I_rstn low, asynchronous): state IDLE; O_busy, O_done, O_misaligned, O_timeout and O_mem_req = 0; O_data and O_mem_addr = 0; timeout counter = 0; latched loadsel and offset = 0.
- Encodings: LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101. Codes 011, 110 and 111 behave as LW.
- States and transitions:
  - IDLE or DONE, I_start=1:
    - Misaligned access (LH/LHU with addr[0]=1, or LW with addr[1:0]!=0): next state DONE, O_done=1, O_misaligned=1, O_data=0, no bus request.
    - Otherwise: latch loadsel and addr[1:0], drive O_mem_addr, next state REQ with O_mem_req=1.
  - IDLE or DONE, I_start=0: next state IDLE.
  - REQ, I_mem_ack=1: capture the extracted I_mem_data into O_data, drop req; next state DONE, O_done=1.
  - REQ, no ack, counter==TIMEOUT-1: drop req; next state DONE, O_done=1, O_timeout=1, O_data=0.
  - REQ, no ack, otherwise: counter increments.
  - Counter clears on entry to REQ.
- O_done, O_misaligned and O_timeout are registered and high for exactly one cycle, in DONE.
- Latency: start sampled at edge 0 → O_mem_req high after edge 0. An ack sampled at edge k gives O_done high for the cycle after edge k. Minimum start-to-done is 2 edges.
- Timeout length: with no ack, O_mem_req is high for exactly TIMEOUT cycles.
- I_start while in REQ is ignored; there is no queueing. The pipeline must use O_busy.
- I_mem_ack outside REQ is ignored. An ack in the first REQ cycle is accepted.
- Extraction:
  - Byte lane is selected by offset: 0 → [7:0], 1 → [15:8], 2 → [23:16], 3 → [31:24].
  - Halfword lane is selected by offset[1]: 0 → [15:0], 1 → [31:16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Reset during REQ: O_mem_req drops immediately, no O_done is produced, and a later ack is ignored.

Decomposition:
- Shared header load_unit.vh: LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LBU, LOAD_LHU defines, plus state encodings IDLE=2'd0, REQ=2'd1, DONE=2'd2.
- One combinational sub-module, load_extractor (I_loadsel, I_offset[1:0], I_data → O_data). It is the read mirror of the store byte/halfword replication logic and is tested standalone.

Test Plan:
- LB, addr 0x00001003, I_mem_data 0x80123456, ack 3 cycles after req → O_mem_addr 0x00001000, O_data 0xFFFFFF80, O_done high exactly 1 cycle, O_busy high 3 cycles.
- LBU same stimulus → 0x00000080. LH addr 0x1002, data 0x80801234 → 0xFFFF8080. LHU same stimulus → 0x00008080.
- LW addr 0x2000, ack in the first REQ cycle, data 0x80808080 → O_done 2 edges after start, O_data 0x80808080. A back-to-back start in the DONE cycle is accepted.
- LH addr 0x1001 and LW addr 0x1002 → O_done and O_misaligned pulse next cycle, O_mem_req never high, O_data 0.
- TIMEOUT=8, ack never asserted → O_mem_req high exactly 8 cycles, then O_done and O_timeout pulse together, O_data 0.
- I_rstn pulled low while O_mem_req=1 → O_mem_req low without waiting for a clock edge. A subsequent ack produces no O_done, and the state returns to IDLE.
